data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-requester arbiter in front of the MIPS-Lite `dataMemory`, sharing its single access port between the pipeline MEM stage (port 0) and a loader/debug master (port 1). Each cycle it grants at most one request, drives `memWriteEnable`/`address`/`dataIn` from the winner, and returns read data registered one cycle later. It supports round-robin or fixed-priority arbitration and a bounded lock for back-to-back accesses by one master.

## Interface
- `DATAPATH_WIDTH`, 32, data word width
- `ADDRESS_WIDTH`, 32, byte address width
- `PRIORITY_MODE`, 0, 0 = round-robin, 1 = fixed priority (port 0 wins)
- `MAX_LOCK`, 4, maximum consecutive locked grants to one port (≥1)

- `clk` in 1 — single clock, rising edge
- `resetN` in 1 — asynchronous, active-low reset
- `req0`/`req1` in 1 — access request, held until granted
- `we0`/`we1` in 1 — 1 = write, 0 = read
- `addr0`/`addr1` in ADDRESS_WIDTH — byte address
- `wdata0`/`wdata1` in DATAPATH_WIDTH — write data
- `lock0`/`lock1` in 1 — request to keep ownership for the next access
- `gnt0`/`gnt1` out 1 — access accepted this cycle (combinational)
- `rvalid0`/`rvalid1` out 1 — read data valid pulse (registered)
- `rdata0`/`rdata1` out DATAPATH_WIDTH — read data (registered, held until next read to that port)
- `memWriteEnable` out 1 — to `dataMemory`
- `address` out ADDRESS_WIDTH — to `dataMemory`
- `dataIn` out DATAPATH_WIDTH — to `dataMemory`
- `dataOut` in DATAPATH_WIDTH — from `dataMemory` (combinational read)

## Operation
- Handshake: requester holds `req`, `we`, `addr`, `wdata`, `lock` stable until the rising edge at which its `gnt` is high; access completes at that edge.
- At most one `gnt` high per cycle; `gnt` only asserts when the matching `req` is high.
- Arbitration, no active lock:
  - Single requester wins.
  - Both requesting, PRIORITY_MODE=1: port 0.
  - Both requesting, PRIORITY_MODE=0: port other than `lastGrant`; `lastGrant` updates on every grant.
- Lock state machine:
  - States: UNLOCKED, LOCKED(owner, count).
  - UNLOCKED→LOCKED when the granted port has `lock`=1; count=1.
  - In LOCKED, if owner has `req`&`lock`, owner is granted and count increments.
  - Owner dropping `req` or `lock` → UNLOCKED immediately; normal arbitration that same cycle.
  - After MAX_LOCK locked grants, force UNLOCKED; the next cycle the other port has priority if requesting, regardless of PRIORITY_MODE.
  - A grant issued without `lock` leaves/keeps UNLOCKED.
- Memory drive: `memWriteEnable` = granted & `we` of winner. `address`/`dataIn` mux the winner; hold port 0 values when idle. `memWriteEnable` is 0 when nothing is granted.
- Reads: `dataOut` is captured into `rdataN` at the grant edge; `rvalidN` is high for exactly the following cycle.
- Writes: no `rvalid`; `rdata` unchanged.

## Timing
- Reset (async assert, sync-safe deassert): `rvalid0/1`=0, `rdata0/1`=0, `lastGrant`=1 (port 0 wins the first tie), UNLOCKED, count=0. Combinational outputs follow inputs during reset, but `gnt0/1` and `memWriteEnable` are forced to 0.
- Grant latency: 0 cycles (same cycle as `req`) when uncontended.
- Read latency: `rvalid` one cycle after grant; write completes at the grant edge.
- Throughput: one access per cycle; alternating grants under continuous contention in round-robin mode.
- Reset mid-lock or mid-read: lock cleared and a pending `rvalid` is dropped; requesters must re-request.
- Read-after-write to the same address on consecutive cycles returns the new data, because of the synchronous write before the combinational read.

## Test plan
- Reset, then `req0` write addr 0x0 data 0x8, then `req0` write addr 0x4 data 0x1234, then reads of 0x0 and 0x4 → `gnt0` same cycle each time; `rdata0`=0x00000008, then 0x00001234, each with a one-cycle `rvalid0`.
- Both ports read continuously, PRIORITY_MODE=0 → grants 0,1,0,1…; `rvalid` pulses alternate; port 1 never waits more than 1 cycle.
- PRIORITY_MODE=1, both requesting for 5 cycles → `gnt0` every cycle, `gnt1`=0; `gnt1` is granted the cycle `req0` drops.
- MAX_LOCK=4, port 1 requests with `lock1`=1 and port 0 requesting throughout → 4 consecutive `gnt1`, then `gnt0`, and no 5th consecutive `gnt1`.
- Port 1 writes 0xDEADBEEF to 0x10; port 0 reads 0x10 the next cycle → `rdata0`=0xDEADBEEF.
- Assert `resetN`=0 while LOCKED with a read granted → `rvalid` stays 0, state is UNLOCKED, and the first tie after release grants port 0.

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// Request/grant bundle between the two requesters, the arbiter and the data memory port.
// slave = arbiter side; master = requesters plus the memory they share.
interface data_memory_arbiter_if #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int ADDRESS_WIDTH  = 32
);
  logic                      req0;
  logic                      req1;
  logic                      we0;
  logic                      we1;
  logic [ADDRESS_WIDTH-1:0]  addr0;
  logic [ADDRESS_WIDTH-1:0]  addr1;
  logic [DATAPATH_WIDTH-1:0] wdata0;
  logic [DATAPATH_WIDTH-1:0] wdata1;
  logic                      lock0;
  logic                      lock1;
  logic                      gnt0;
  logic                      gnt1;
  logic                      rvalid0;
  logic                      rvalid1;
  logic [DATAPATH_WIDTH-1:0] rdata0;
  logic [DATAPATH_WIDTH-1:0] rdata1;
  logic                      memWriteEnable;
  logic [ADDRESS_WIDTH-1:0]  address;
  logic [DATAPATH_WIDTH-1:0] dataIn;
  logic [DATAPATH_WIDTH-1:0] dataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, dataOut,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, memWriteEnable, address, dataIn
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, dataOut,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, memWriteEnable, address, dataIn
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter for the single data memory port: zero-cycle grant, read data one cycle later.
// Losers simply hold req until granted; a locking owner keeps the port for at most MAX_LOCK grants.
module data_memory_arbiter #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int MAX_LOCK       = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  data_memory_arbiter_if.slave  bus
);

  localparam int            CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t state, state_nxt;
  logic        owner, owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_run;
  logic        last_grant, last_grant_nxt;
  logic        force_vld, force_vld_nxt;
  logic        force_port, force_port_nxt;
  logic        keep;
  logic        pick;
  logic        g0;
  logic        g1;
  logic        win_lock;

  logic                      rvalid0_r;
  logic                      rvalid1_r;
  logic [DATAPATH_WIDTH-1:0] rdata0_r;
  logic [DATAPATH_WIDTH-1:0] rdata1_r;
  logic [ADDRESS_WIDTH-1:0]  addr_mux;
  logic [DATAPATH_WIDTH-1:0] wdata_mux;

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    cnt_nxt        = cnt;
    cnt_run        = '0;
    last_grant_nxt = last_grant;
    force_vld_nxt  = 1'b0;
    force_port_nxt = force_port;
    pick           = 1'b0;
    g0             = 1'b0;
    g1             = 1'b0;

    keep = (state == LOCKED) &&
           (owner ? (bus.req1 && bus.lock1) : (bus.req0 && bus.lock0));

    if (keep) begin
      g0 = ~owner;
      g1 = owner;
    end else if (bus.req0 && bus.req1) begin
      // A just-expired lock hands the next tie to the other port, whatever the mode.
      if (force_vld)
        pick = force_port;
      else if (PRIORITY_MODE == 1)
        pick = 1'b0;
      else
        pick = ~last_grant;
      g0 = ~pick;
      g1 = pick;
    end else begin
      g0 = bus.req0;
      g1 = bus.req1;
    end

    if (!resetN) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end

    win_lock = g1 ? bus.lock1 : bus.lock0;

    if (g0 || g1) begin
      last_grant_nxt = g1;
      if (win_lock) begin
        cnt_run = keep ? (cnt + CW'(1)) : CW'(1);
        if (cnt_run >= MAX_CNT) begin
          state_nxt      = UNLOCKED;
          cnt_nxt        = '0;
          force_vld_nxt  = 1'b1;
          force_port_nxt = ~g1;
        end else begin
          state_nxt = LOCKED;
          cnt_nxt   = cnt_run;
          owner_nxt = g1;
        end
      end else begin
        state_nxt = UNLOCKED;
        cnt_nxt   = '0;
      end
    end else begin
      state_nxt = UNLOCKED;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= UNLOCKED;
      owner      <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      force_vld  <= 1'b0;
      force_port <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      force_vld  <= force_vld_nxt;
      force_port <= force_port_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
    end else begin
      rvalid0_r <= g0 && !bus.we0;
      rvalid1_r <= g1 && !bus.we1;
      if (g0 && !bus.we0)
        rdata0_r <= bus.dataOut;
      if (g1 && !bus.we1)
        rdata1_r <= bus.dataOut;
    end
  end

  // Port 0 drives the memory bus whenever port 1 is not the winner, including idle.
  assign addr_mux  = g1 ? bus.addr1  : bus.addr0;
  assign wdata_mux = g1 ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0           = g0;
  assign bus.gnt1           = g1;
  assign bus.memWriteEnable = (g0 && bus.we0) || (g1 && bus.we1);
  assign bus.address        = addr_mux;
  assign bus.dataIn         = wdata_mux;
  assign bus.rvalid0        = rvalid0_r;
  assign bus.rvalid1        = rvalid1_r;
  assign bus.rdata0         = rdata0_r;
  assign bus.rdata1         = rdata1_r;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: a round-robin and a fixed-priority instance share one stimulus stream,
// each with its own memory, checked every cycle against a rule-level model plus hand-computed literals.
module tb_data_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ML = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_arbiter_if #(.DATAPATH_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_rr ();
  data_memory_arbiter_if #(.DATAPATH_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_fp ();

  data_memory_arbiter #(.DATAPATH_WIDTH(DW), .ADDRESS_WIDTH(AW), .PRIORITY_MODE(0), .MAX_LOCK(ML))
    u_rr (.clk(clk), .resetN(resetN), .bus(bus_rr.slave));
  data_memory_arbiter #(.DATAPATH_WIDTH(DW), .ADDRESS_WIDTH(AW), .PRIORITY_MODE(1), .MAX_LOCK(ML))
    u_fp (.clk(clk), .resetN(resetN), .bus(bus_fp.slave));

  assign bus_rr.req0 = req0;     assign bus_fp.req0 = req0;
  assign bus_rr.req1 = req1;     assign bus_fp.req1 = req1;
  assign bus_rr.we0 = we0;       assign bus_fp.we0 = we0;
  assign bus_rr.we1 = we1;       assign bus_fp.we1 = we1;
  assign bus_rr.lock0 = lock0;   assign bus_fp.lock0 = lock0;
  assign bus_rr.lock1 = lock1;   assign bus_fp.lock1 = lock1;
  assign bus_rr.addr0 = addr0;   assign bus_fp.addr0 = addr0;
  assign bus_rr.addr1 = addr1;   assign bus_fp.addr1 = addr1;
  assign bus_rr.wdata0 = wdata0; assign bus_fp.wdata0 = wdata0;
  assign bus_rr.wdata1 = wdata1; assign bus_fp.wdata1 = wdata1;

  // Behavioural dataMemory per instance: synchronous write, combinational read.
  logic [31:0] mem_rr [64];
  logic [31:0] mem_fp [64];
  always @(posedge clk) if (bus_rr.memWriteEnable) mem_rr[bus_rr.address[7:2]] <= bus_rr.dataIn;
  always @(posedge clk) if (bus_fp.memWriteEnable) mem_fp[bus_fp.address[7:2]] <= bus_fp.dataIn;
  assign bus_rr.dataOut = mem_rr[bus_rr.address[7:2]];
  assign bus_fp.dataOut = mem_fp[bus_fp.address[7:2]];

  // Index 0 = round-robin instance, 1 = fixed-priority instance.
  logic [1:0]  o_gnt0, o_gnt1, o_rv0, o_rv1, o_we;
  logic [31:0] o_rd0 [2];
  logic [31:0] o_rd1 [2];
  logic [31:0] o_addr [2];
  logic [31:0] o_din [2];
  assign o_gnt0 = {bus_fp.gnt0, bus_rr.gnt0};
  assign o_gnt1 = {bus_fp.gnt1, bus_rr.gnt1};
  assign o_rv0  = {bus_fp.rvalid0, bus_rr.rvalid0};
  assign o_rv1  = {bus_fp.rvalid1, bus_rr.rvalid1};
  assign o_we   = {bus_fp.memWriteEnable, bus_rr.memWriteEnable};
  assign o_rd0[0] = bus_rr.rdata0;   assign o_rd0[1] = bus_fp.rdata0;
  assign o_rd1[0] = bus_rr.rdata1;   assign o_rd1[1] = bus_fp.rdata1;
  assign o_addr[0] = bus_rr.address; assign o_addr[1] = bus_fp.address;
  assign o_din[0] = bus_rr.dataIn;   assign o_din[1] = bus_fp.dataIn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Model state: who won last, length of the current locked streak and its owner, a reference memory.
  int          m_last   [2];
  int          m_streak [2];
  int          m_sport  [2];
  logic [31:0] ref_mem  [2][64];
  logic        exp_rv0  [2];
  logic        exp_rv1  [2];
  logic [31:0] exp_rd0  [2];
  logic [31:0] exp_rd1  [2];

  task automatic model_cycle(input int k);
    string       tag;
    int          w;
    bit          hit, kept;
    logic        r [2];
    logic        l [2];
    logic        wr [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [31:0] exp_addr, exp_din;
    tag = (k == 0) ? "rr" : "fp";
    r[0] = req0;   r[1] = req1;
    l[0] = lock0;  l[1] = lock1;
    wr[0] = we0;   wr[1] = we1;
    a[0] = addr0;  a[1] = addr1;
    d[0] = wdata0; d[1] = wdata1;

    if (!resetN) begin
      m_last[k] = 1; m_streak[k] = 0; m_sport[k] = 0;
      exp_rv0[k] = 1'b0; exp_rv1[k] = 1'b0; exp_rd0[k] = '0; exp_rd1[k] = '0;
      check({tag, "_rst_rvalid0"}, 32'(o_rv0[k]), 32'd0);
      check({tag, "_rst_rvalid1"}, 32'(o_rv1[k]), 32'd0);
      check({tag, "_rst_rdata0"}, o_rd0[k], 32'd0);
      check({tag, "_rst_rdata1"}, o_rd1[k], 32'd0);
      check({tag, "_rst_gnt0"}, 32'(o_gnt0[k]), 32'd0);
      check({tag, "_rst_gnt1"}, 32'(o_gnt1[k]), 32'd0);
      check({tag, "_rst_we"}, 32'(o_we[k]), 32'd0);
      return;
    end

    check({tag, "_rvalid0"}, 32'(o_rv0[k]), 32'(exp_rv0[k]));
    check({tag, "_rvalid1"}, 32'(o_rv1[k]), 32'(exp_rv1[k]));
    check({tag, "_rdata0"}, o_rd0[k], exp_rd0[k]);
    check({tag, "_rdata1"}, o_rd1[k], exp_rd1[k]);

    hit  = (m_streak[k] == ML);
    kept = (m_streak[k] > 0) && !hit && r[m_sport[k]] && l[m_sport[k]];
    if (kept)
      w = m_sport[k];
    else if (r[0] && r[1])
      w = hit ? (1 - m_sport[k]) : ((k == 1) ? 0 : (1 - m_last[k]));
    else if (r[0])
      w = 0;
    else if (r[1])
      w = 1;
    else
      w = -1;

    exp_addr = (w == 1) ? a[1] : a[0];
    exp_din  = (w == 1) ? d[1] : d[0];
    check({tag, "_gnt0"}, 32'(o_gnt0[k]), 32'(w == 0));
    check({tag, "_gnt1"}, 32'(o_gnt1[k]), 32'(w == 1));
    check({tag, "_memWriteEnable"}, 32'(o_we[k]), 32'((w >= 0) && wr[(w >= 0) ? w : 0]));
    check({tag, "_address"}, o_addr[k], exp_addr);
    check({tag, "_dataIn"}, o_din[k], exp_din);

    exp_rv0[k] = 1'b0;
    exp_rv1[k] = 1'b0;
    if (w >= 0) begin
      m_streak[k] = l[w] ? (kept ? m_streak[k] + 1 : 1) : 0;
      m_last[k]   = w;
      m_sport[k]  = w;
      if (wr[w]) begin
        ref_mem[k][a[w][7:2]] = d[w];
      end else if (w == 0) begin
        exp_rv0[k] = 1'b1;
        exp_rd0[k] = ref_mem[k][a[0][7:2]];
      end else begin
        exp_rv1[k] = 1'b1;
        exp_rd1[k] = ref_mem[k][a[1][7:2]];
      end
    end else begin
      m_streak[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    #1;
    model_cycle(0);
    model_cycle(1);
  end

  task automatic drive(input logic rst,
                       input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0, input logic l0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1, input logic l1);
    @(negedge clk);
    resetN = rst;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    #2;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_rr[i] = '0; mem_fp[i] = '0; ref_mem[0][i] = '0; ref_mem[1][i] = '0;
    end
    resetN = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lit_reset_rvalid0", 32'(bus_rr.rvalid0), 32'd0);
    check("lit_reset_rdata0", bus_rr.rdata0, 32'd0);
    idle();

    // Port 0 writes then reads back, uncontended.
    drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lit_wr0_gnt0", 32'(bus_rr.gnt0), 32'd1);
    check("lit_wr0_we", 32'(bus_rr.memWriteEnable), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h4, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lit_wr4_gnt0", 32'(bus_rr.gnt0), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lit_rd0_gnt0", 32'(bus_rr.gnt0), 32'd1);
    check("lit_after_wr_rvalid0", 32'(bus_rr.rvalid0), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lit_rd0_rvalid0", 32'(bus_rr.rvalid0), 32'd1);
    check("lit_rd0_rdata0", bus_rr.rdata0, 32'h0000_0008);
    idle();
    check("lit_rd4_rdata0", bus_rr.rdata0, 32'h0000_1234);
    idle();
    check("lit_rvalid0_pulse", 32'(bus_rr.rvalid0), 32'd0);
    check("lit_rdata0_held", bus_rr.rdata0, 32'h0000_1234);

    // Both ports read for 5 cycles, then port 0 drops.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      check("lit_rr_alt_gnt1", 32'(bus_rr.gnt1), 32'((c % 2) == 0));
      check("lit_fp_gnt0", 32'(bus_fp.gnt0), 32'd1);
      if (c == 1) begin
        check("lit_rr_rvalid1", 32'(bus_rr.rvalid1), 32'd1);
        check("lit_rr_rdata1", bus_rr.rdata1, 32'h0000_1234);
        check("lit_fp_rdata0", bus_fp.rdata0, 32'h0000_0008);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    check("lit_fp_gnt1_on_drop", 32'(bus_fp.gnt1), 32'd1);
    idle();

    // Port 1 locks while port 0 requests throughout: rr gives 0,1,1,1,1,0,1.
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
      check("lit_rr_lock_gnt1", 32'(bus_rr.gnt1), 32'((c >= 1 && c <= 4) || c == 6));
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    check("lit_rr_unlock_gnt0", 32'(bus_rr.gnt0), 32'd1);
    idle();

    // Lock taken uncontended, then held against port 0 in both modes until MAX_LOCK.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
      check("lit_fp_lock_gnt1", 32'(bus_fp.gnt1), 32'(c < 3));
      check("lit_rr_lock2_gnt1", 32'(bus_rr.gnt1), 32'(c < 3));
    end

    // Write by port 1 followed immediately by a read of the same word on port 0.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    check("lit_wr10_gnt1", 32'(bus_rr.gnt1), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("lit_rd10_gnt0", 32'(bus_rr.gnt0), 32'd1);
    idle();
    check("lit_raw_rdata0", bus_rr.rdata0, 32'hDEAD_BEEF);
    check("lit_raw_rvalid0", 32'(bus_rr.rvalid0), 32'd1);

    // Reset while port 1 holds a lock and a read is in flight.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    check("lit_midrst_rvalid1", 32'(bus_rr.rvalid1), 32'd0);
    check("lit_midrst_rdata1", bus_rr.rdata1, 32'd0);
    check("lit_midrst_gnt1", 32'(bus_rr.gnt1), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    check("lit_post_rst_rr_gnt0", 32'(bus_rr.gnt0), 32'd1);
    check("lit_post_rst_fp_gnt0", 32'(bus_fp.gnt0), 32'd1);
    idle();
    check("lit_post_rst_rdata0", bus_rr.rdata0, 32'h0000_0008);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
